// File: rtl/wb_merge_unit.sv
// Multi-channel writeback merge: per-producer FIFOs, load byte/half formatting,
// round-robin arbitration onto one registered regfile write port with retire order.
module wb_merge_unit #(
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 4,
  parameter int CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [NUM_CH-1:0]     in_valid,
  output logic [NUM_CH-1:0]     in_ready,
  input  logic [NUM_CH-1:0]     in_we,
  input  logic [NUM_CH*5-1:0]   in_rd,
  input  logic [NUM_CH*32-1:0]  in_data,
  input  logic [NUM_CH*3-1:0]   in_sel,
  input  logic [NUM_CH*2-1:0]   in_off,
  output logic                  regf_we,
  output logic [4:0]            rd_sel,
  output logic [31:0]           rd_v,
  output logic                  retire_valid,
  output logic [CHW-1:0]        retire_ch,
  output logic [63:0]           order
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]  wptr_q [NUM_CH];
  logic [AW-1:0]  wptr_d [NUM_CH];
  logic [AW-1:0]  rptr_q [NUM_CH];
  logic [AW-1:0]  rptr_d [NUM_CH];
  logic [CW-1:0]  count_q [NUM_CH];
  logic [CW-1:0]  count_d [NUM_CH];

  logic           we_mem_q   [NUM_CH][DEPTH];
  logic [4:0]     rd_mem_q   [NUM_CH][DEPTH];
  logic [31:0]    data_mem_q [NUM_CH][DEPTH];
  logic [2:0]     sel_mem_q  [NUM_CH][DEPTH];
  logic [1:0]     off_mem_q  [NUM_CH][DEPTH];

  logic [CHW-1:0] rr_q, rr_d;
  logic [63:0]    cnt_q, cnt_d;

  logic           regf_we_q, regf_we_d;
  logic [4:0]     rd_sel_q, rd_sel_d;
  logic [31:0]    rd_v_q, rd_v_d;
  logic           retire_valid_q, retire_valid_d;
  logic [CHW-1:0] retire_ch_q, retire_ch_d;
  logic [63:0]    order_q, order_d;

  logic [NUM_CH-1:0] enq, deq, nonempty;
  logic              grant_vld, take;
  logic [CHW-1:0]    grant;
  logic              head_we;
  logic [4:0]        head_rd;
  logic [31:0]       head_data;
  logic [2:0]        head_sel;
  logic [1:0]        head_off;
  int                idx;

  function automatic logic [31:0] fmt_load(input logic [31:0] d, input logic [2:0] sel,
                                           input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{off, 3'b000} +: 8];
    h = off[1] ? d[31:16] : d[15:0];
    case (sel)
      3'd1:    fmt_load = {{24{b[7]}}, b};
      3'd2:    fmt_load = {24'd0, b};
      3'd3:    fmt_load = {{16{h[15]}}, h};
      3'd4:    fmt_load = {16'd0, h};
      default: fmt_load = d;
    endcase
  endfunction

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      in_ready[c] = count_q[c] < CW'(DEPTH);
      nonempty[c] = count_q[c] != '0;
      enq[c]      = in_valid[c] && in_ready[c] && !flush;
    end
  end

  // Search starts one past the last winner so every busy channel is served in turn.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    idx       = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = (int'(rr_q) + i) % NUM_CH;
      if (!grant_vld && nonempty[idx]) begin
        grant_vld = 1'b1;
        grant     = CHW'(idx);
      end
    end
    take = grant_vld && !flush;
    deq  = '0;
    if (take) deq[grant] = 1'b1;
    head_we   = we_mem_q[grant][rptr_q[grant]];
    head_rd   = rd_mem_q[grant][rptr_q[grant]];
    head_data = data_mem_q[grant][rptr_q[grant]];
    head_sel  = sel_mem_q[grant][rptr_q[grant]];
    head_off  = off_mem_q[grant][rptr_q[grant]];
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      wptr_d[c]  = wptr_q[c];
      rptr_d[c]  = rptr_q[c];
      count_d[c] = count_q[c] + CW'(enq[c]) - CW'(deq[c]);
      if (enq[c]) wptr_d[c] = wptr_q[c] + AW'(1);
      if (deq[c]) rptr_d[c] = rptr_q[c] + AW'(1);
      if (flush) begin
        wptr_d[c]  = '0;
        rptr_d[c]  = '0;
        count_d[c] = '0;
      end
    end
    rr_d           = take ? grant : rr_q;
    cnt_d          = take ? cnt_q + 64'd1 : cnt_q;
    regf_we_d      = take && head_we && (head_rd != 5'd0);
    rd_sel_d       = regf_we_d ? head_rd : 5'd0;
    rd_v_d         = regf_we_d ? fmt_load(head_data, head_sel, head_off) : 32'd0;
    retire_valid_d = take;
    retire_ch_d    = take ? grant : '0;
    order_d        = take ? cnt_q : order_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wptr_q[c]  <= '0;
        rptr_q[c]  <= '0;
        count_q[c] <= '0;
      end
      rr_q           <= CHW'(NUM_CH - 1);
      cnt_q          <= '0;
      regf_we_q      <= 1'b0;
      rd_sel_q       <= '0;
      rd_v_q         <= '0;
      retire_valid_q <= 1'b0;
      retire_ch_q    <= '0;
      order_q        <= '0;
    end else begin
      wptr_q         <= wptr_d;
      rptr_q         <= rptr_d;
      count_q        <= count_d;
      rr_q           <= rr_d;
      cnt_q          <= cnt_d;
      regf_we_q      <= regf_we_d;
      rd_sel_q       <= rd_sel_d;
      rd_v_q         <= rd_v_d;
      retire_valid_q <= retire_valid_d;
      retire_ch_q    <= retire_ch_d;
      order_q        <= order_d;
    end
  end

  // Payload storage carries no reset; occupancy is tracked solely by the pointers.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (enq[c]) begin
        we_mem_q[c][wptr_q[c]]   <= in_we[c];
        rd_mem_q[c][wptr_q[c]]   <= in_rd[c*5 +: 5];
        data_mem_q[c][wptr_q[c]] <= in_data[c*32 +: 32];
        sel_mem_q[c][wptr_q[c]]  <= in_sel[c*3 +: 3];
        off_mem_q[c][wptr_q[c]]  <= in_off[c*2 +: 2];
      end
    end
  end

  assign regf_we      = regf_we_q;
  assign rd_sel       = rd_sel_q;
  assign rd_v         = rd_v_q;
  assign retire_valid = retire_valid_q;
  assign retire_ch    = retire_ch_q;
  assign order        = order_q;

endmodule

// File: tb/tb_wb_merge_unit.sv
// Directed bench for wb_merge_unit with per-channel scoreboard queues.
module tb_wb_merge_unit;
  localparam int NUM_CH = 2;
  localparam int DEPTH  = 4;
  localparam int CHW    = 1;

  logic              clk = 1'b0;
  logic              rst, flush;
  logic [1:0]        in_valid, in_ready, in_we;
  logic [9:0]        in_rd;
  logic [63:0]       in_data;
  logic [5:0]        in_sel;
  logic [3:0]        in_off;
  logic              regf_we, retire_valid;
  logic [4:0]        rd_sel;
  logic [31:0]       rd_v;
  logic [CHW-1:0]    retire_ch;
  logic [63:0]       order;

  always #5 clk = ~clk;

  wb_merge_unit #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .CHW(CHW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we), .in_rd(in_rd),
    .in_data(in_data), .in_sel(in_sel), .in_off(in_off),
    .regf_we(regf_we), .rd_sel(rd_sel), .rd_v(rd_v),
    .retire_valid(retire_valid), .retire_ch(retire_ch), .order(order)
  );

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [2:0]  sel;
    logic [1:0]  off;
    logic [31:0] exp;
  } req_t;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] v;
  } ret_t;

  req_t        pend0[$], pend1[$];
  ret_t        sb0[$], sb1[$];
  req_t        cur0, cur1;
  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_order = 64'd0;
  logic        stall0 = 1'b0;

  function automatic logic [31:0] fmt_model(input logic [31:0] d, input logic [2:0] sel,
                                            input logic [1:0] off);
    logic [31:0] sb, sh;
    sb = d >> (off * 8);
    sh = d >> (off[1] * 16);
    case (sel)
      3'd1:    return {{24{sb[7]}}, sb[7:0]};
      3'd2:    return sb & 32'h0000_00FF;
      3'd3:    return {{16{sh[15]}}, sh[15:0]};
      3'd4:    return sh & 32'h0000_FFFF;
      default: return d;
    endcase
  endfunction

  function automatic req_t mk(input logic we, input logic [4:0] rd, input logic [31:0] data,
                              input logic [2:0] sel, input logic [1:0] off, input logic [31:0] exp);
    req_t r;
    r.we = we; r.rd = rd; r.data = data; r.sel = sel; r.off = off; r.exp = exp;
    return r;
  endfunction

  function automatic ret_t to_ret(input req_t r);
    ret_t t;
    t.we = r.we && (r.rd != 5'd0);
    t.rd = t.we ? r.rd : 5'd0;
    t.v  = t.we ? r.exp : 32'd0;
    return t;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int c, input req_t r);
    in_valid[c]       = 1'b1;
    in_we[c]          = r.we;
    in_rd[c*5 +: 5]   = r.rd;
    in_data[c*32 +: 32] = r.data;
    in_sel[c*3 +: 3]  = r.sel;
    in_off[c*2 +: 2]  = r.off;
  endtask

  task automatic kick();
    if (!in_valid[0] && pend0.size() > 0) begin cur0 = pend0.pop_front(); drive(0, cur0); end
    if (!in_valid[1] && pend1.size() > 0) begin cur1 = pend1.pop_front(); drive(1, cur1); end
  endtask

  task automatic tick();
    logic [1:0] acc;
    logic       fl, rs, ok;
    ret_t       e;
    acc = in_valid & in_ready;
    fl  = flush;
    rs  = rst;
    if (in_valid[0] && !in_ready[0]) stall0 = 1'b1;
    @(posedge clk);
    #1;
    if (rs || fl) begin
      sb0.delete();
      sb1.delete();
      if (rs) exp_order = 64'd0;
      chk("idle_retire_valid", {63'd0, retire_valid}, 64'd0);
      chk("idle_regf_we", {63'd0, regf_we}, 64'd0);
      chk("idle_rd_v", {32'd0, rd_v}, 64'd0);
      chk("idle_rd_sel", {59'd0, rd_sel}, 64'd0);
      chk("idle_retire_ch", {63'd0, retire_ch}, 64'd0);
      if (rs) chk("rst_order", order, 64'd0);
    end else begin
      if (acc[0]) begin sb0.push_back(to_ret(cur0)); in_valid[0] = 1'b0; end
      if (acc[1]) begin sb1.push_back(to_ret(cur1)); in_valid[1] = 1'b0; end
      if (retire_valid) begin
        ok = 1'b1;
        if (retire_ch == 1'b0) begin
          if (sb0.size() == 0) ok = 1'b0; else e = sb0.pop_front();
        end else begin
          if (sb1.size() == 0) ok = 1'b0; else e = sb1.pop_front();
        end
        chk("sb_expected_entry", {63'd0, ok}, 64'd1);
        if (ok) begin
          chk("sb_regf_we", {63'd0, regf_we}, {63'd0, e.we});
          chk("sb_rd_sel", {59'd0, rd_sel}, {59'd0, e.rd});
          chk("sb_rd_v", {32'd0, rd_v}, {32'd0, e.v});
          chk("sb_order", order, exp_order);
        end
        exp_order++;
      end else begin
        chk("nogrant_regf_we", {63'd0, regf_we}, 64'd0);
        chk("nogrant_rd_v", {32'd0, rd_v}, 64'd0);
        chk("nogrant_rd_sel", {59'd0, rd_sel}, 64'd0);
        chk("nogrant_retire_ch", {63'd0, retire_ch}, 64'd0);
      end
      kick();
    end
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while ((sb0.size() > 0 || sb1.size() > 0 || pend0.size() > 0 || pend1.size() > 0 ||
            in_valid != 2'b00) && n < max) begin
      tick();
      n++;
    end
    chk("drain_in_budget", (n < max) ? 64'd1 : 64'd0, 64'd1);
  endtask

  initial begin
    logic [63:0] o_before;
    req_t        r;
    rst = 1'b1; flush = 1'b0;
    in_valid = '0; in_we = '0; in_rd = '0; in_data = '0; in_sel = '0; in_off = '0;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", {62'd0, in_ready}, 64'd3);

    // Single lb on ch1, first transaction after reset
    pend1.push_back(mk(1'b1, 5'd5, 32'h80FF_7F01, 3'd1, 2'd2, 32'hFFFF_FFFF));
    kick();
    tick();
    chk("t1_not_yet", {63'd0, retire_valid}, 64'd0);
    tick();
    chk("t1_valid", {63'd0, retire_valid}, 64'd1);
    chk("t1_we", {63'd0, regf_we}, 64'd1);
    chk("t1_rd_sel", {59'd0, rd_sel}, 64'd5);
    chk("t1_rd_v", {32'd0, rd_v}, 64'hFFFF_FFFF);
    chk("t1_ch", {63'd0, retire_ch}, 64'd1);
    chk("t1_order", order, 64'd0);

    // Format sweep
    pend0.push_back(mk(1'b1, 5'd1, 32'h8001_FF7F, 3'd2, 2'd3, 32'h0000_0080));
    pend0.push_back(mk(1'b1, 5'd2, 32'h8001_FF7F, 3'd3, 2'd2, 32'hFFFF_8001));
    pend0.push_back(mk(1'b1, 5'd3, 32'h8001_FF7F, 3'd4, 2'd0, 32'h0000_FF7F));
    pend0.push_back(mk(1'b1, 5'd4, 32'h8001_FF7F, 3'd5, 2'd1, 32'h8001_FF7F));
    pend0.push_back(mk(1'b1, 5'd6, 32'h8001_FF7F, 3'd0, 2'd2, 32'h8001_FF7F));
    pend0.push_back(mk(1'b1, 5'd7, 32'h8001_FF7F, 3'd7, 2'd1, 32'h8001_FF7F));
    kick();
    drain(50);

    // Round-robin from a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pend0.push_back(mk(1'b1, 5'(10 + i), 32'hA000_0000 + i, 3'd0, 2'd0, 32'hA000_0000 + i));
      pend1.push_back(mk(1'b1, 5'(20 + i), 32'hB000_0000 + i, 3'd0, 2'd0, 32'hB000_0000 + i));
    end
    kick();
    tick();
    chk("t3_first_idle", {63'd0, retire_valid}, 64'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t3_valid", {63'd0, retire_valid}, 64'd1);
      chk("t3_ch", {63'd0, retire_ch}, 64'(i % 2));
      chk("t3_order", order, 64'(i));
    end
    drain(10);

    // Backpressure: both channels streaming faster than one retire per cycle
    stall0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      r = mk(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
             3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 32'd0);
      r.exp = fmt_model(r.data, r.sel, r.off);
      pend0.push_back(r);
      r = mk(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
             3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 32'd0);
      r.exp = fmt_model(r.data, r.sel, r.off);
      pend1.push_back(r);
    end
    kick();
    drain(200);
    chk("t4_ch0_backpressured", {63'd0, stall0}, 64'd1);

    // x0 destination still retires
    o_before = exp_order;
    pend1.push_back(mk(1'b1, 5'd0, 32'h0000_1234, 3'd0, 2'd0, 32'h0000_1234));
    kick();
    tick();
    tick();
    chk("t5_valid", {63'd0, retire_valid}, 64'd1);
    chk("t5_we", {63'd0, regf_we}, 64'd0);
    chk("t5_rd_v", {32'd0, rd_v}, 64'd0);
    chk("t5_order", order, o_before);

    // Flush with two entries queued at order 7
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 7; i++)
      pend0.push_back(mk(1'b1, 5'd9, 32'(i), 3'd0, 2'd0, 32'(i)));
    kick();
    drain(50);
    chk("t6_order_before", order, 64'd6);
    pend0.push_back(mk(1'b1, 5'd11, 32'h1111, 3'd0, 2'd0, 32'h1111));
    pend1.push_back(mk(1'b1, 5'd12, 32'h2222, 3'd0, 2'd0, 32'h2222));
    kick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t6_ready_after_flush", {62'd0, in_ready}, 64'd3);
    tick();
    chk("t6_nothing_left", {63'd0, retire_valid}, 64'd0);
    pend1.push_back(mk(1'b1, 5'd13, 32'h3333, 3'd0, 2'd0, 32'h3333));
    kick();
    drain(20);
    chk("t6_order_kept", order, 64'd7);

    // Reset on the same edge as a grant
    pend0.push_back(mk(1'b1, 5'd14, 32'h4444, 3'd0, 2'd0, 32'h4444));
    kick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("t6_no_retire_after_rst", {63'd0, retire_valid}, 64'd0);
    pend1.push_back(mk(1'b1, 5'd15, 32'h5555, 3'd0, 2'd0, 32'h5555));
    kick();
    drain(20);
    chk("t6_order_restart", order, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
